// File: rtl/pc_pkg.sv
// Shared types, constants and strobe priority decode for the picoMIPS program counter.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INCR   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_JUMP   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_t;

  localparam int PC_RESET_VAL = 0;

  // Stall outranks everything; then ret, call, jump, branch, incr.
  function automatic pc_op_t pc_decode(
    input logic stall,
    input logic ret,
    input logic call,
    input logic jump,
    input logic branch,
    input logic incr
  );
    pc_op_t op;
    if (stall)       op = OP_HOLD;
    else if (ret)    op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (jump)   op = OP_JUMP;
    else if (branch) op = OP_BRANCH;
    else if (incr)   op = OP_INCR;
    else             op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty is ignored.
module pc_ras_stack
  import pc_pkg::*;
#(
  parameter int P_SIZE = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [P_SIZE-1:0] push_data,
  output logic [P_SIZE-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [P_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_inc;
  logic [PW-1:0]     ptr_dec;
  logic [CW-1:0]     count;

  // ptr names the next free slot, so the top of stack sits one slot below it.
  assign ptr_inc  = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign ptr_dec  = (ptr == '0) ? LAST : ptr - 1'b1;
  assign top_data = mem[ptr_dec];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with branch/jump/stall and an optional return-address
// stack, enabled by defining PC_RAS_EN (otherwise call = jump, ret = incr).
module pc_ras
  import pc_pkg::*;
#(
  parameter int P_SIZE   = 6,
  parameter int OFF_SIZE = 6,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PCstall,
  input  logic                PCincr,
  input  logic                PCbranch,
  input  logic                PCjump,
  input  logic                PCcall,
  input  logic                PCret,
  input  logic [OFF_SIZE-1:0] Offset,
  input  logic [P_SIZE-1:0]   Target,
  output logic [P_SIZE-1:0]   PCout,
  output logic                StackFull,
  output logic                StackEmpty,
  output logic                StackErr
);

  localparam int W = (OFF_SIZE > P_SIZE) ? OFF_SIZE : P_SIZE;

  pc_op_t            op;
  logic [P_SIZE-1:0] pc_inc;
  logic [P_SIZE-1:0] pc_br;
  logic [P_SIZE-1:0] ret_pc;
  logic [P_SIZE-1:0] next_pc;

  assign op     = pc_decode(PCstall, PCret, PCcall, PCjump, PCbranch, PCincr);
  assign pc_inc = PCout + 1'b1;
  // Add at the wider of the two widths, then keep the low P_SIZE bits.
  assign pc_br  = P_SIZE'(W'($signed(Offset)) + W'(PCout));

`ifdef PC_RAS_EN
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [P_SIZE-1:0] top_data;

  assign push = (op == OP_CALL);
  assign pop  = (op == OP_RET) && !empty;

  pc_ras_stack #(
    .P_SIZE (P_SIZE),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty)
  );

  assign StackFull  = full;
  assign StackEmpty = empty;
  assign ret_pc     = empty ? pc_inc : top_data;

  // Overflow and underflow both latch the error until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StackErr <= 1'b0;
    end else if (((op == OP_CALL) && full) || ((op == OP_RET) && empty)) begin
      StackErr <= 1'b1;
    end
  end
`else
  assign StackFull  = 1'b0;
  assign StackEmpty = 1'b1;
  assign StackErr   = 1'b0;
  assign ret_pc     = pc_inc;
`endif

  always_comb begin
    next_pc = PCout;
    case (op)
      OP_HOLD:   next_pc = PCout;
      OP_INCR:   next_pc = pc_inc;
      OP_BRANCH: next_pc = pc_br;
      OP_JUMP:   next_pc = Target;
      OP_CALL:   next_pc = Target;
      OP_RET:    next_pc = ret_pc;
      default:   next_pc = PCout;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) PCout <= P_SIZE'(PC_RESET_VAL);
    else       PCout <= next_pc;
  end

endmodule

// File: tb/tb_pc_ras.sv
// Directed scoreboard bench for pc_ras; expectations follow whether PC_RAS_EN is defined.
module tb_pc_ras;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  // strobe vector order: {stall, ret, call, jump, branch, incr}
  localparam logic [5:0] S_INC = 6'b000001;
  localparam logic [5:0] S_BR  = 6'b000010;
  localparam logic [5:0] S_JMP = 6'b000100;
  localparam logic [5:0] S_CAL = 6'b001000;
  localparam logic [5:0] S_RET = 6'b010000;
  localparam logic [5:0] S_STL = 6'b100000;

  typedef struct packed {
    logic [5:0] pc;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       PCstall, PCincr, PCbranch, PCjump, PCcall, PCret;
  logic [5:0] Offset;
  logic [5:0] Target;
  logic [5:0] PCout;
  logic       StackFull, StackEmpty, StackErr;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  pc_ras #(.P_SIZE(6), .OFF_SIZE(6), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCstall    (PCstall),
    .PCincr     (PCincr),
    .PCbranch   (PCbranch),
    .PCjump     (PCjump),
    .PCcall     (PCcall),
    .PCret      (PCret),
    .Offset     (Offset),
    .Target     (Target),
    .PCout      (PCout),
    .StackFull  (StackFull),
    .StackEmpty (StackEmpty),
    .StackErr   (StackErr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic compare_head();
    exp_t  e;
    exp_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {PCout, StackFull, StackEmpty, StackErr};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got pc=%0d full=%b empty=%b err=%b, expected pc=%0d full=%b empty=%b err=%b",
             t, o.pc, o.full, o.empty, o.err, e.pc, e.full, e.empty, e.err);
    end
  endtask

  task automatic push_exp(input logic [5:0] pc_r, input logic [5:0] pc_p,
                          input logic f, input logic em, input logic er, input string tag);
    exp_t e;
    e.pc    = RAS ? pc_r : pc_p;
    e.full  = RAS ? f  : 1'b0;
    e.empty = RAS ? em : 1'b1;
    e.err   = RAS ? er : 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drive one cycle of strobes, then check one edge later.
  task automatic step(input logic [5:0] s, input logic [5:0] tgt, input logic [5:0] off,
                      input logic [5:0] pc_r, input logic [5:0] pc_p,
                      input logic f, input logic em, input logic er, input string tag);
    {PCstall, PCret, PCcall, PCjump, PCbranch, PCincr} = s;
    Target = tgt;
    Offset = off;
    push_exp(pc_r, pc_p, f, em, er, tag);
    @(posedge clk);
    #1;
    compare_head();
    @(negedge clk);
    {PCstall, PCret, PCcall, PCjump, PCbranch, PCincr} = 6'b000000;
  endtask

  // Pulse reset between edges and check the outputs before any clock edge.
  task automatic mid_reset(input string tag);
    reset = 1'b1;
    push_exp(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, tag);
    #1;
    compare_head();
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    {PCstall, PCret, PCcall, PCjump, PCbranch, PCincr} = 6'b000000;
    Target = 6'd0;
    Offset = 6'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_exp(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, "reset_state");
    compare_head();

    for (int i = 1; i <= 5; i++)
      step(S_INC, 6'd0, 6'd0, 6'(i), 6'(i), 1'b0, 1'b1, 1'b0, "incr");
    mid_reset("mid_reset_1");

    step(S_JMP, 6'd63, 6'd0, 6'd63, 6'd63, 1'b0, 1'b1, 1'b0, "jump_63");
    step(S_INC, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0, "incr_wrap");
    step(S_INC, 6'd0, 6'd0, 6'd1, 6'd1, 1'b0, 1'b1, 1'b0, "incr_1");
    step(S_BR, 6'd0, 6'h3d, 6'd62, 6'd62, 1'b0, 1'b1, 1'b0, "branch_m3");
    step(S_BR, 6'd0, 6'd5, 6'd3, 6'd3, 1'b0, 1'b1, 1'b0, "branch_p5");

    step(S_JMP, 6'd10, 6'd0, 6'd10, 6'd10, 1'b0, 1'b1, 1'b0, "jump_10");
    step(S_CAL, 6'd40, 6'd0, 6'd40, 6'd40, 1'b0, 1'b0, 1'b0, "call_40");
    step(S_RET, 6'd0, 6'd0, 6'd11, 6'd41, 1'b0, 1'b1, 1'b0, "ret_11");

    step(S_JMP, 6'd1, 6'd0, 6'd1, 6'd1, 1'b0, 1'b1, 1'b0, "jump_1");
    step(S_CAL, 6'd2, 6'd0, 6'd2, 6'd2, 1'b0, 1'b0, 1'b0, "call_a");
    step(S_CAL, 6'd3, 6'd0, 6'd3, 6'd3, 1'b0, 1'b0, 1'b0, "call_b");
    step(S_CAL, 6'd4, 6'd0, 6'd4, 6'd4, 1'b0, 1'b0, 1'b0, "call_c");
    step(S_CAL, 6'd5, 6'd0, 6'd5, 6'd5, 1'b1, 1'b0, 1'b0, "call_full");
    step(S_CAL, 6'd6, 6'd0, 6'd6, 6'd6, 1'b1, 1'b0, 1'b1, "call_overflow");
    step(S_RET, 6'd0, 6'd0, 6'd6, 6'd7, 1'b0, 1'b0, 1'b1, "ret_6");
    step(S_RET, 6'd0, 6'd0, 6'd5, 6'd8, 1'b0, 1'b0, 1'b1, "ret_5");
    step(S_RET, 6'd0, 6'd0, 6'd4, 6'd9, 1'b0, 1'b0, 1'b1, "ret_4");
    step(S_RET, 6'd0, 6'd0, 6'd3, 6'd10, 1'b0, 1'b1, 1'b1, "ret_3");
    step(S_RET, 6'd0, 6'd0, 6'd4, 6'd11, 1'b0, 1'b1, 1'b1, "ret_underflow");
    mid_reset("mid_reset_2");

    step(S_JMP, 6'd10, 6'd0, 6'd10, 6'd10, 1'b0, 1'b1, 1'b0, "jump_10b");
    step(S_STL | S_CAL | S_INC, 6'd40, 6'd0, 6'd10, 6'd10, 1'b0, 1'b1, 1'b0, "stall_wins");
    step(S_CAL | S_JMP, 6'd20, 6'd0, 6'd20, 6'd20, 1'b0, 1'b0, 1'b0, "call_over_jump");
    step(S_STL | S_RET, 6'd0, 6'd0, 6'd20, 6'd20, 1'b0, 1'b0, 1'b0, "stall_ret");
    step(S_RET | S_CAL, 6'd30, 6'd0, 6'd11, 6'd21, 1'b0, 1'b1, 1'b0, "ret_over_call");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised picoMIPS program counter with increment, relative branch, absolute jump, stall, and a hardware return-address stack (RAS) for call/return. Sits in the fetch stage and drives the instruction-memory address. The decoder supplies one-hot-ish command strobes, and this block resolves their priority internally. Successor to the plain increment-only counter.

## Interface
- P_SIZE, 6: PC width in bits; program space is 2^P_SIZE words.
- OFF_SIZE, 6: width of the signed branch offset.
- DEPTH, 4: RAS entries; must be ≥2.

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- PCstall  in  1  freeze all state this cycle
- PCincr  in  1  PC ← PC+1
- PCbranch  in  1  PC ← PC + sign-extended Offset
- PCjump  in  1  PC ← Target
- PCcall  in  1  push PC+1, PC ← Target
- PCret  in  1  PC ← popped return address
- Offset  in  OFF_SIZE  signed two's-complement branch displacement
- Target  in  P_SIZE  absolute jump/call destination
- PCout  out  P_SIZE  current PC (registered)
- StackFull  out  1  RAS holds DEPTH entries
- StackEmpty  out  1  RAS holds 0 entries
- StackErr  out  1  sticky overflow/underflow flag

## Operation
- One operation per cycle. Priority: PCstall > PCret > PCcall > PCjump > PCbranch > PCincr > hold.
- Arithmetic is modulo 2^P_SIZE: PC+1 wraps 2^P_SIZE−1 → 0. Branch is relative to the current PCout, not PC+1. Offset is sign-extended to P_SIZE before addition; if OFF_SIZE > P_SIZE, it is truncated after the add.
- RAS is a circular buffer with a count register in the range 0..DEPTH.
- Call, not full: write PCout+1 at top, count+1.
- Call, full: the oldest entry is overwritten (circular), count stays DEPTH, and StackErr ← 1. The jump to Target still occurs.
- Ret, not empty: PCout ← top entry, count−1.
- Ret, empty: PCout ← PCout+1 (treated as increment), count stays 0, and StackErr ← 1.
- StackErr is sticky and is cleared only by reset.
- Stall: PCout, RAS contents, count, and StackErr are all unchanged, whatever other strobes are asserted.
- Reset, asynchronous and effective mid-operation: PCout=0, count=0, StackFull=0, StackEmpty=1, StackErr=0. RAS storage contents are don't-care.

## Timing
- All state updates on the rising edge of clk. An operation takes effect on PCout one edge after its strobe is sampled.
- StackFull and StackEmpty decode combinationally from the count register, so they are valid in the same cycle as the count.
- Call and ret in consecutive cycles: the ret returns the just-pushed PC+1. No bypass hazard exists, because push and pop are registered.
- Reset assertion clears outputs immediately without waiting for a clock edge. Deassertion is synchronised externally.

## Configuration
- PC_RAS_EN defined: the RAS and the flags behave as described above.
- PC_RAS_EN undefined: no RAS storage is generated.
  - PCcall behaves exactly as PCjump.
  - PCret behaves exactly as PCincr.
  - StackFull=0, StackEmpty=1, and StackErr=0 are tied constants.
  - Priority order is unchanged.

## Structure
- Package pc_pkg holds:
  - enum pc_op_t: OP_HOLD, OP_INCR, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET.
  - constant PC_RESET_VAL = 0.
  - the priority-decode function from the strobes to pc_op_t.
- Sub-module pc_ras_stack is parameterised by P_SIZE and DEPTH. It has push/pop/data ports, circular pointer, count, and full/empty outputs, plus asynchronous reset.
- The top level holds the PC register, the next-PC mux, and the StackErr flag.

## Test plan
All cases use P_SIZE=6, OFF_SIZE=6, DEPTH=4 unless stated.
1. Increment and reset: PCincr for 5 cycles → PCout=5. Assert reset between edges → PCout=0 and StackEmpty=1 before the next edge.
2. Wrap and branch:
   - PCjump Target=63, then PCincr → PCout=0.
   - PCincr (PCout=1), then PCbranch Offset=−3 → PCout=62.
   - PCbranch Offset=+5 → PCout=3.
3. Call/return: at PCout=10, PCcall Target=40 → PCout=40, StackEmpty=0. Then PCret → PCout=11, StackEmpty=1, StackErr=0.
4. Overflow and underflow:
   - Calls from PCs 1, 2, 3, 4, 5 (each Target = next PC): StackFull=1 after the 4th call; the 5th sets StackErr=1.
   - Four rets return 6, 5, 4, 3.
   - A 5th ret gives PCout+1 with StackErr still 1.
5. Priority:
   - PCstall+PCcall+PCincr → PCout and count unchanged.
   - PCcall+PCjump, Target=20 → PCout=20 and one entry pushed.
   - PCret+PCcall on a non-empty stack → pop only.
6. PC_RAS_EN undefined: at PCout=10, PCcall Target=40 → PCout=40. Then PCret → 41. StackFull=0, StackEmpty=1, StackErr=0 throughout.
